// File: rtl/mc_db_pkg.sv
// -----------------------------------------------------------------------------
// mc_db_pkg
// Shared definitions for the multi-channel debounced event counter with a
// scanned hex display:
//   mode_e      - count mode encoding carried on the 2-bit mode input
//   SEG_TABLE   - 16-entry hex glyph table, bit order g..a (bit 6 = g, bit 0 = a)
//   SEG_BLANK   - all segments dark
//   nib_to_seg  - nibble to 7-segment glyph lookup
// -----------------------------------------------------------------------------
package mc_db_pkg;

    typedef enum logic [1:0] {
        MODE_RISE = 2'b00,
        MODE_FALL = 2'b01,
        MODE_BOTH = 2'b10,
        MODE_HOLD = 2'b11
    } mode_e;

    // Active-high segments, bits 6:0 = g f e d c b a.
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h3F, // 0
        7'h06, // 1
        7'h5B, // 2
        7'h4F, // 3
        7'h66, // 4
        7'h6D, // 5
        7'h7D, // 6
        7'h07, // 7
        7'h7F, // 8
        7'h6F, // 9
        7'h77, // A
        7'h7C, // b
        7'h39, // C
        7'h5E, // d
        7'h79, // E
        7'h71  // F
    };

    localparam logic [7:0] SEG_BLANK = 8'h00;

    function automatic logic [6:0] nib_to_seg(input logic [3:0] nib);
        return SEG_TABLE[nib];
    endfunction

endpackage

// File: rtl/db_chan.sv
// -----------------------------------------------------------------------------
// db_chan
// One switch channel: 2-flop synchronizer, counting debouncer and edge
// detector.
//
// Ports
//   clk     in   single clock, rising edge
//   rst     in   synchronous active-high reset
//   sw_raw  in   raw asynchronous switch level
//   rise    out  one-cycle pulse, registered together with the db 0->1 update
//   fall    out  one-cycle pulse, registered together with the db 1->0 update
//
// The debounced level follows the synchronized input only after the two have
// disagreed for DB_CYCLES consecutive cycles; a single agreeing cycle restarts
// the stability count.
// -----------------------------------------------------------------------------
module db_chan #(
    parameter int DB_CYCLES = 2_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic sw_raw,
    output logic rise,
    output logic fall
);

    // Counter holds 0..DB_CYCLES-1; DB_CYCLES >= 2 keeps the width >= 1.
    localparam int STAB_W = $clog2(DB_CYCLES);

    logic              sync1_q, sync1_d;
    logic              sync2_q, sync2_d;
    logic              db_q,    db_d;
    logic [STAB_W-1:0] stab_q,  stab_d;
    logic              rise_q,  rise_d;
    logic              fall_q,  fall_d;

    always_comb begin
        sync1_d = sw_raw;
        sync2_d = sync1_q;
        db_d    = db_q;
        stab_d  = '0;
        rise_d  = 1'b0;
        fall_d  = 1'b0;

        if (sync2_q != db_q) begin
            // The current cycle is the DB_CYCLES-th consecutive disagreement
            // when the count already holds DB_CYCLES-1.
            if (stab_q == STAB_W'(DB_CYCLES - 1)) begin
                db_d   = sync2_q;
                stab_d = '0;
                rise_d = sync2_q;
                fall_d = ~sync2_q;
            end else begin
                stab_d = stab_q + STAB_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            db_q    <= 1'b0;
            stab_q  <= '0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            db_q    <= db_d;
            stab_q  <= stab_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign rise = rise_q;
    assign fall = fall_q;

endmodule

// File: rtl/mc_db_cnt_disp.sv
// -----------------------------------------------------------------------------
// mc_db_cnt_disp
// N_CH debounced switch channels, each feeding an event counter selected by
// mode, plus a multiplexed hex display of one selected counter.
//
// Parameters
//   N_CH       number of switch channels (1..16)
//   CNT_W      counter width, multiple of 4 (4..16); DIGITS = CNT_W/4
//   DB_CYCLES  consecutive stable cycles before a debounced level changes
//   SCAN_DIV   clock cycles each display digit stays selected
//   SAT        1 = counters stick at all-ones, 0 = counters wrap to 0
//
// Ports
//   clk       in   single clock, rising edge
//   rst       in   synchronous active-high reset
//   sw        in   [N_CH]          raw asynchronous switch levels
//   clr       in   clear all counters and overflow flags (wins over counting)
//   mode      in   [2]             00 rise, 01 fall, 10 both edges, 11 hold
//   ch_sel    in   [4]             channel shown on the display
//   cnt_flat  out  [N_CH*CNT_W]    counter i at [i*CNT_W +: CNT_W]
//   ovf       out  [N_CH]          sticky overflow / saturation flags
//   seg_sel   out  [DIGITS]        one-hot digit enable, registered
//   seg_led   out  [8]             dp + g..a segments, registered
// -----------------------------------------------------------------------------
module mc_db_cnt_disp
    import mc_db_pkg::*;
#(
    parameter int N_CH      = 2,
    parameter int CNT_W     = 8,
    parameter int DB_CYCLES = 2_000_000,
    parameter int SCAN_DIV  = 200_000,
    parameter int SAT       = 0,
    localparam int DIGITS   = CNT_W / 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_CH-1:0]        sw,
    input  logic                   clr,
    input  logic [1:0]             mode,
    input  logic [3:0]             ch_sel,
    output logic [N_CH*CNT_W-1:0]  cnt_flat,
    output logic [N_CH-1:0]        ovf,
    output logic [DIGITS-1:0]      seg_sel,
    output logic [7:0]             seg_led
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int DIG_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    // Mode is evaluated in the cycle the edge pulse is high.
    function automatic logic count_en(input logic [1:0] m,
                                      input logic       r,
                                      input logic       f);
        logic en;
        case (mode_e'(m))
            MODE_RISE: en = r;
            MODE_FALL: en = f;
            MODE_BOTH: en = r | f;
            default:   en = 1'b0;
        endcase
        return en;
    endfunction

    logic [N_CH-1:0] rise;
    logic [N_CH-1:0] fall;

    logic [CNT_W-1:0] cnt_q [N_CH];
    logic [CNT_W-1:0] cnt_d [N_CH];
    logic [N_CH-1:0]  ovf_q, ovf_d;

    // ---------------------------------------------------------------------
    // Per-channel front end and flattened counter view
    // ---------------------------------------------------------------------
    for (genvar g = 0; g < N_CH; g++) begin : g_chan
        db_chan #(
            .DB_CYCLES (DB_CYCLES)
        ) u_db_chan (
            .clk    (clk),
            .rst    (rst),
            .sw_raw (sw[g]),
            .rise   (rise[g]),
            .fall   (fall[g])
        );

        assign cnt_flat[g*CNT_W +: CNT_W] = cnt_q[g];
    end

    // ---------------------------------------------------------------------
    // Event counters
    // ---------------------------------------------------------------------
    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        for (int i = 0; i < N_CH; i++) begin
            if (clr) begin
                cnt_d[i] = '0;
                ovf_d[i] = 1'b0;
            end else if (count_en(mode, rise[i], fall[i])) begin
                if (&cnt_q[i]) begin
                    ovf_d[i] = 1'b1;
                    cnt_d[i] = (SAT != 0) ? cnt_q[i] : '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_CH; i++) begin
                cnt_q[i] <= '0;
            end
            ovf_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;

    // ---------------------------------------------------------------------
    // Scan divider and digit index
    // ---------------------------------------------------------------------
    logic [DIV_W-1:0] div_q, div_d;
    logic [DIG_W-1:0] dig_q, dig_d;

    always_comb begin
        div_d = div_q + DIV_W'(1);
        dig_d = dig_q;
        if (div_q == DIV_W'(SCAN_DIV - 1)) begin
            div_d = '0;
            dig_d = (dig_q == DIG_W'(DIGITS - 1)) ? '0 : dig_q + DIG_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q <= '0;
            dig_q <= '0;
        end else begin
            div_q <= div_d;
            dig_q <= dig_d;
        end
    end

    // ---------------------------------------------------------------------
    // Display mux and registered segment outputs
    // ---------------------------------------------------------------------
    logic [CNT_W-1:0]  sel_cnt;
    logic              sel_ovf;
    logic              sel_ok;
    logic [3:0]        nib;
    logic [DIGITS-1:0] seg_sel_q, seg_sel_d;
    logic [7:0]        seg_led_q, seg_led_d;

    always_comb begin
        sel_cnt = '0;
        sel_ovf = 1'b0;
        sel_ok  = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            if (int'(ch_sel) == i) begin
                sel_cnt = cnt_q[i];
                sel_ovf = ovf_q[i];
                sel_ok  = 1'b1;
            end
        end

        // Index 0 is the leftmost digit, so it carries the top nibble.
        nib = '0;
        for (int j = 0; j < DIGITS; j++) begin
            if (dig_q == DIG_W'(j)) begin
                nib = sel_cnt[(DIGITS-1-j)*4 +: 4];
            end
        end

        seg_sel_d = DIGITS'(1) << dig_q;
        seg_led_d = SEG_BLANK;
        if (sel_ok) begin
            seg_led_d = {sel_ovf && (dig_q == '0), nib_to_seg(nib)};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seg_sel_q <= DIGITS'(1);
            seg_led_q <= SEG_BLANK;
        end else begin
            seg_sel_q <= seg_sel_d;
            seg_led_q <= seg_led_d;
        end
    end

    assign seg_sel = seg_sel_q;
    assign seg_led = seg_led_q;

endmodule

// File: tb/tb_mc_db_cnt_disp.sv
module tb_mc_db_cnt_disp;

    localparam int N_CH   = 2;
    localparam int CNT_W  = 8;
    localparam int DBC    = 4;
    localparam int SD     = 3;
    localparam int DIGITS = 2;

    logic        clk = 1'b0;
    logic        rst, clr;
    logic [1:0]  sw, mode;
    logic [3:0]  ch_sel;
    logic [15:0] cnt0, cnt1;
    logic [1:0]  ovf0, ovf1, sel0, sel1;
    logic [7:0]  led0, led1;

    always #5 clk = ~clk;

    mc_db_cnt_disp #(.N_CH(N_CH), .CNT_W(CNT_W), .DB_CYCLES(DBC), .SCAN_DIV(SD), .SAT(0)) u_dut0 (
        .clk(clk), .rst(rst), .sw(sw), .clr(clr), .mode(mode), .ch_sel(ch_sel),
        .cnt_flat(cnt0), .ovf(ovf0), .seg_sel(sel0), .seg_led(led0));

    mc_db_cnt_disp #(.N_CH(N_CH), .CNT_W(CNT_W), .DB_CYCLES(DBC), .SCAN_DIV(SD), .SAT(1)) u_dut1 (
        .clk(clk), .rst(rst), .sw(sw), .clr(clr), .mode(mode), .ch_sel(ch_sel),
        .cnt_flat(cnt1), .ovf(ovf1), .seg_sel(sel1), .seg_led(led1));

    int n_cmp = 0;
    int n_err = 0;

    logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Reference model state: index [k] is the DUT (0 = wrap, 1 = saturate).
    int   m_sy0 [N_CH];
    int   m_sy1 [N_CH];
    int   m_db  [N_CH];
    int   m_run [N_CH];
    bit   m_rise[N_CH];
    bit   m_fall[N_CH];
    int   m_cnt [2][N_CH];
    bit   m_ovf [2][N_CH];
    int   m_n = 0;
    logic [1:0] exp_sel [2];
    logic [7:0] exp_led [2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One rising edge worth of specified behaviour.
    task automatic model_edge();
        int dig, nib, c;
        bit q;
        logic [7:0] led;
        if (rst) begin
            for (int i = 0; i < N_CH; i++) begin
                m_sy0[i] = 0; m_sy1[i] = 0; m_db[i] = 0; m_run[i] = 0;
                m_rise[i] = 0; m_fall[i] = 0;
                for (int k = 0; k < 2; k++) begin
                    m_cnt[k][i] = 0; m_ovf[k][i] = 0;
                end
            end
            m_n = 0;
            for (int k = 0; k < 2; k++) begin
                exp_sel[k] = 2'b01; exp_led[k] = 8'h00;
            end
        end else begin
            // Display reflects the state present before this edge.
            dig = (m_n / SD) % DIGITS;
            c = int'(ch_sel);
            for (int k = 0; k < 2; k++) begin
                exp_sel[k] = 2'(1 << dig);
                led = 8'h00;
                if (c < N_CH) begin
                    nib = (m_cnt[k][c] >> ((DIGITS - 1 - dig) * 4)) & 15;
                    led = {1'b0, glyph[nib]};
                    if (dig == 0 && m_ovf[k][c]) led[7] = 1'b1;
                end
                exp_led[k] = led;
            end
            m_n++;
            // Counters consume the edge pulses produced on the previous edge.
            for (int i = 0; i < N_CH; i++) begin
                q = (mode == 2'b00 && m_rise[i]) || (mode == 2'b01 && m_fall[i]) ||
                    (mode == 2'b10 && (m_rise[i] || m_fall[i]));
                for (int k = 0; k < 2; k++) begin
                    if (clr) begin
                        m_cnt[k][i] = 0; m_ovf[k][i] = 0;
                    end else if (q) begin
                        if (m_cnt[k][i] == 255) begin
                            m_ovf[k][i] = 1;
                            m_cnt[k][i] = (k == 1) ? 255 : 0;
                        end else begin
                            m_cnt[k][i] = m_cnt[k][i] + 1;
                        end
                    end
                end
            end
            // Debounce: level follows after DBC consecutive disagreeing samples.
            for (int i = 0; i < N_CH; i++) begin
                m_rise[i] = 0; m_fall[i] = 0;
                if (m_sy1[i] != m_db[i]) begin
                    m_run[i]++;
                    if (m_run[i] == DBC) begin
                        m_db[i] = m_sy1[i];
                        m_run[i] = 0;
                        m_rise[i] = (m_db[i] == 1);
                        m_fall[i] = (m_db[i] == 0);
                    end
                end else begin
                    m_run[i] = 0;
                end
                m_sy1[i] = m_sy0[i];
                m_sy0[i] = int'(sw[i]);
            end
        end
    endtask

    task automatic step();
        logic [15:0] ef [2];
        logic [1:0]  eo [2];
        @(posedge clk);
        model_edge();
        #1;
        for (int k = 0; k < 2; k++) begin
            ef[k] = {8'(m_cnt[k][1]), 8'(m_cnt[k][0])};
            eo[k] = {m_ovf[k][1], m_ovf[k][0]};
        end
        chk("model cnt dut0", 32'(cnt0), 32'(ef[0]));
        chk("model ovf dut0", 32'(ovf0), 32'(eo[0]));
        chk("model sel dut0", 32'(sel0), 32'(exp_sel[0]));
        chk("model led dut0", 32'(led0), 32'(exp_led[0]));
        chk("model cnt dut1", 32'(cnt1), 32'(ef[1]));
        chk("model ovf dut1", 32'(ovf1), 32'(eo[1]));
        chk("model sel dut1", 32'(sel1), 32'(exp_sel[1]));
        chk("model led dut1", 32'(led1), 32'(exp_led[1]));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    typedef struct {
        logic [1:0] sw;
        logic [1:0] mode;
        int         ncyc;
        logic [7:0] c0;
        logic [7:0] c1;
    } vec_t;

    vec_t tbl [12];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] prev, seen;
        bit found;

        tbl[0]  = '{2'b01, 2'b00, 6,  8'h00, 8'h00};
        tbl[1]  = '{2'b01, 2'b00, 1,  8'h01, 8'h00};
        tbl[2]  = '{2'b01, 2'b00, 3,  8'h01, 8'h00};
        tbl[3]  = '{2'b00, 2'b00, 10, 8'h01, 8'h00};
        tbl[4]  = '{2'b01, 2'b10, 8,  8'h02, 8'h00};
        tbl[5]  = '{2'b00, 2'b10, 8,  8'h03, 8'h00};
        tbl[6]  = '{2'b01, 2'b11, 8,  8'h03, 8'h00};
        tbl[7]  = '{2'b00, 2'b11, 8,  8'h03, 8'h00};
        tbl[8]  = '{2'b10, 2'b01, 8,  8'h03, 8'h00};
        tbl[9]  = '{2'b00, 2'b01, 8,  8'h03, 8'h01};
        tbl[10] = '{2'b11, 2'b00, 8,  8'h04, 8'h02};
        tbl[11] = '{2'b00, 2'b00, 8,  8'h04, 8'h02};

        // Reset state
        rst = 1'b1; clr = 1'b0; sw = 2'b00; mode = 2'b00; ch_sel = 4'd0;
        run(3);
        chk("reset cnt", 32'(cnt0), 32'h0);
        chk("reset ovf", 32'(ovf0), 32'h0);
        chk("reset seg_sel", 32'(sel0), 32'h1);
        chk("reset seg_led", 32'(led0), 32'h0);
        rst = 1'b0;

        // Table-driven vectors
        for (int i = 0; i < 12; i++) begin
            sw = tbl[i].sw; mode = tbl[i].mode;
            run(tbl[i].ncyc);
            chk($sformatf("vec%0d cnt0", i), 32'(cnt0[7:0]), 32'(tbl[i].c0));
            chk($sformatf("vec%0d cnt1", i), 32'(cnt0[15:8]), 32'(tbl[i].c1));
            chk($sformatf("vec%0d sat cnt0", i), 32'(cnt1[7:0]), 32'(tbl[i].c0));
        end

        // Bouncing input yields a single count once it settles
        mode = 2'b00;
        for (int p = 0; p < 5; p++) begin
            sw = 2'b01; run(2);
            sw = 2'b00; run(2);
        end
        chk("bounce no count", 32'(cnt0[7:0]), 32'h04);
        sw = 2'b01; run(10);
        chk("bounce settled", 32'(cnt0[7:0]), 32'h05);
        sw = 2'b00; run(10);
        chk("bounce release", 32'(cnt0[7:0]), 32'h05);

        // clr in the same cycle as an increment
        sw = 2'b01; run(6);
        clr = 1'b1; run(1);
        chk("clr collide cnt", 32'(cnt0), 32'h0);
        chk("clr collide ovf", 32'(ovf0), 32'h0);
        clr = 1'b0; run(2);
        chk("clr no late inc", 32'(cnt0), 32'h0);

        // Build 0xA5 then check the scanned display
        mode = 2'b10;
        for (int t = 0; t < 165; t++) begin
            sw[0] = ~sw[0]; run(7);
        end
        chk("a5 cnt0", 32'(cnt0[7:0]), 32'hA5);
        chk("a5 sat cnt0", 32'(cnt1[7:0]), 32'hA5);
        ch_sel = 4'd0;
        run(1);
        prev = sel0; found = 0;
        for (int t = 0; t < 12 && !found; t++) begin
            step();
            if (prev == 2'b10 && sel0 == 2'b01) found = 1;
            prev = sel0;
        end
        chk("scan sync found", 32'(found), 32'h1);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("scan sel c%0d", i), 32'(sel0), (i < 3) ? 32'h1 : 32'h2);
            chk($sformatf("scan led c%0d", i), 32'(led0), (i < 3) ? 32'h77 : 32'h6D);
            run(1);
        end
        chk("scan wrap sel", 32'(sel0), 32'h1);
        ch_sel = 4'd5; run(1);
        chk("bad ch_sel blank", 32'(led0), 32'h0);
        seen = sel0;
        for (int i = 0; i < 6; i++) begin
            run(1);
            seen = seen | sel0;
            chk($sformatf("bad ch_sel blank c%0d", i), 32'(led0), 32'h0);
        end
        chk("bad ch_sel still scans", 32'(seen), 32'h3);

        // Overflow: wrap vs saturate, dp on digit 0
        ch_sel = 4'd0;
        clr = 1'b1; run(1); clr = 1'b0;
        for (int t = 0; t < 255; t++) begin
            sw[0] = ~sw[0]; run(7);
        end
        chk("255 wrap cnt", 32'(cnt0[7:0]), 32'hFF);
        chk("255 wrap ovf", 32'(ovf0), 32'h0);
        chk("255 sat cnt", 32'(cnt1[7:0]), 32'hFF);
        sw[0] = ~sw[0]; run(7);
        chk("256 wrap cnt", 32'(cnt0[7:0]), 32'h00);
        chk("256 wrap ovf", 32'(ovf0), 32'h1);
        chk("256 sat cnt", 32'(cnt1[7:0]), 32'hFF);
        chk("256 sat ovf", 32'(ovf1), 32'h1);
        chk("256 ch1 untouched", 32'(cnt0[15:8]), 32'h0);
        run(1);
        for (int t = 0; t < 8 && sel0 != 2'b01; t++) step();
        chk("dp digit0 sel", 32'(sel0), 32'h1);
        chk("dp wrap led", 32'(led0), 32'hBF);
        chk("dp sat led", 32'(led1), 32'hF1);

        // Reset mid-debounce discards the partial count
        mode = 2'b00;
        clr = 1'b1; run(1); clr = 1'b0;
        sw = 2'b01; run(3);
        rst = 1'b1; run(1); rst = 1'b0;
        run(6);
        chk("rst mid-db no early", 32'(cnt0[7:0]), 32'h0);
        run(1);
        chk("rst mid-db count", 32'(cnt0[7:0]), 32'h1);
        // Reset release with db previously high produces no event
        rst = 1'b1; sw = 2'b00; mode = 2'b10; run(1); rst = 1'b0;
        run(10);
        chk("rst release no event", 32'(cnt0), 32'h0);

        // Randomized phase against the model
        for (int t = 0; t < 4000; t++) begin
            rst = ($urandom % 400 == 0);
            clr = ($urandom % 150 == 0);
            if ($urandom % 40 == 0) mode = 2'($urandom);
            if ($urandom % 60 == 0) ch_sel = 4'($urandom % 7);
            for (int b = 0; b < N_CH; b++)
                if ($urandom % 6 == 0) sw[b] = ~sw[b];
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
